// File: rtl/axilite_initiator_if.sv
// Bundle of the command/response stream and the five AXI4-Lite channels
// seen by axilite_initiator.
// Ports: master = initiator view (drives AW/W/AR valids, B/R readies, cmd_ready, rsp_*);
//        slave  = environment view (issues commands, plays the AXI-Lite register slave).
interface axilite_initiator_if #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned IP_DATA_WIDTH = 32
);
    // command / response stream
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_wen;
    logic [ADDR_WIDTH-1:0]    cmd_addr;
    logic [IP_DATA_WIDTH-1:0] cmd_wdata;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_err;
    logic [IP_DATA_WIDTH-1:0] rsp_rdata;

    // AXI4-Lite write channels
    logic                     awvalid;
    logic                     awready;
    logic [ADDR_WIDTH-1:0]    awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH/8-1:0]  wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;

    // AXI4-Lite read channels
    logic                     arvalid;
    logic                     arready;
    logic [ADDR_WIDTH-1:0]    araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;

    modport master (
        input  cmd_valid, cmd_wen, cmd_addr, cmd_wdata, rsp_ready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready
    );

    modport slave (
        output cmd_valid, cmd_wen, cmd_addr, cmd_wdata, rsp_ready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready
    );
endinterface

// File: rtl/axilite_initiator.sv
// Purpose: AXI4-Lite manager turning one command into FOLD register beats and one response.
// Latency: request in the cycle after cmd accept / after each B or R; rsp_valid the cycle after the last B/R.
// Backpressure: one command at a time (cmd_ready only in IDLE); response held until rsp_ready; waits on AXI readies.
//
// Ports: aclk, aresetn (synchronous, active-low); bus (axilite_initiator_if.master) carries the
//        cmd_*/rsp_* stream and the AW/W/B/AR/R channels. All AXI outputs come from flops.
// Option: define AXILITE_INITIATOR_TIMEOUT_EN to abandon a command after TIMEOUT_CYCLES cycles
//         without progress in any bus-wait state (reports rsp_err = 1).
module axilite_initiator #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned IP_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    axilite_initiator_if.master bus
);
    localparam int unsigned FOLD      = (IP_DATA_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int unsigned BSEL_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WSEL_BITS = (FOLD > 1) ? $clog2(FOLD) : 0;
    localparam int unsigned CNT_W     = (FOLD > 1) ? $clog2(FOLD) : 1;
    localparam int unsigned PAD_W     = FOLD * DATA_WIDTH;
    // Clears the byte-select and word-select bits of the command address.
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
        ~((ADDR_WIDTH'(1) << (BSEL_BITS + WSEL_BITS)) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WREQ, ST_WRESP, ST_RREQ, ST_RDATA, ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [CNT_W-1:0]        beat_inc;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [PAD_W-1:0]        wdata_q, wdata_d;
    logic [PAD_W-1:0]        rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   wbeat_q, wbeat_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [PAD_W-1:0]        cmd_wdata_pad;
    logic                    unused_bits;

`ifdef AXILITE_INITIATOR_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             busy;
`endif

    assign cmd_wdata_pad = PAD_W'(bus.cmd_wdata);
    assign beat_inc      = beat_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        wbeat_d     = wbeat_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q gates the handshake: it is still low in the first
                // cycle after reset release even though state is already IDLE.
                if (bus.cmd_valid && cmd_ready_q) begin
                    beat_d  = '0;
                    err_d   = 1'b0;
                    addr_d  = bus.cmd_addr & BASE_MASK;
                    wdata_d = cmd_wdata_pad;
                    rdata_d = '0;
                    wbeat_d = cmd_wdata_pad[DATA_WIDTH-1:0];
                    if (bus.cmd_wen) begin
                        state_d   = ST_WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RREQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WREQ: begin
                // AW and W retire independently; move on once both are gone.
                awvalid_d = awvalid_q && !bus.awready;
                wvalid_d  = wvalid_q && !bus.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WRESP;
                    bready_d = 1'b1;
                end
            end
            ST_WRESP: begin
                if (bus.bvalid) begin
                    err_d    = err_q | bus.bresp[1];
                    bready_d = 1'b0;
                    if (beat_q == LAST_BEAT) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        beat_d    = beat_inc;
                        wbeat_d   = wdata_q[int'(beat_inc)*DATA_WIDTH +: DATA_WIDTH];
                        state_d   = ST_WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            ST_RREQ: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (bus.rvalid) begin
                    rdata_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = bus.rdata;
                    err_d    = err_q | bus.rresp[1];
                    rready_d = 1'b0;
                    if (beat_q == LAST_BEAT) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        beat_d    = beat_inc;
                        state_d   = ST_RREQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef AXILITE_INITIATOR_TIMEOUT_EN
        // tmo_q counts the cycles already spent in the current wait state, so
        // tmo_q == TIMEOUT_CYCLES-1 marks the TIMEOUT_CYCLES-th cycle of waiting.
        busy = state_q inside {ST_WREQ, ST_WRESP, ST_RREQ, ST_RDATA};
        if (busy && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            err_d       = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
        end
        tmo_d = (busy && state_d == state_q) ? tmo_q + TMO_W'(1) : '0;
`endif

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wbeat_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
`ifdef AXILITE_INITIATOR_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            wbeat_q     <= wbeat_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef AXILITE_INITIATOR_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Beat address: base with word-select field replaced by the beat index.
    assign bus.awaddr    = addr_q | (ADDR_WIDTH'(beat_q) << BSEL_BITS);
    assign bus.araddr    = addr_q | (ADDR_WIDTH'(beat_q) << BSEL_BITS);
    assign bus.awprot    = 3'b000;
    assign bus.arprot    = 3'b000;
    assign bus.awvalid   = awvalid_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.wdata     = wbeat_q;
    assign bus.wstrb     = '1;
    assign bus.bready    = bready_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q[IP_DATA_WIDTH-1:0];

    // Only the SLVERR/DECERR bit of a response matters; read bits above
    // IP_DATA_WIDTH are dropped.
    assign unused_bits = ^{bus.bresp[0], bus.rresp[0], rdata_q, wdata_q, (TIMEOUT_CYCLES != 0)};
endmodule

// File: tb/tb_axilite_initiator.sv
module tb_axilite_initiator;
    localparam int AW = 16;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    // dut_a: 64-bit IP word over a 32-bit bus (two beats); dut_b: single beat.
    axilite_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .IP_DATA_WIDTH(64)) ifa ();
    axilite_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .IP_DATA_WIDTH(32)) ifb ();

    axilite_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .IP_DATA_WIDTH(64), .TIMEOUT_CYCLES(16))
        dut_a (.aclk(aclk), .aresetn(aresetn), .bus(ifa));
    axilite_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .IP_DATA_WIDTH(32), .TIMEOUT_CYCLES(16))
        dut_b (.aclk(aclk), .aresetn(aresetn), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Issue one command to dut_a; returns in the cycle after acceptance.
    task automatic a_cmd(input logic wen, input logic [AW-1:0] addr, input logic [63:0] wd);
        chk("a_cmd_ready_idle", ifa.cmd_ready, 1'b1);
        ifa.cmd_valid = 1'b1;
        ifa.cmd_wen   = wen;
        ifa.cmd_addr  = addr;
        ifa.cmd_wdata = wd;
        tick();
        ifa.cmd_valid = 1'b0;
        chk("a_cmd_ready_busy", ifa.cmd_ready, 1'b0);
    endtask

    // AW/W phase of one write beat; awready/wready pulse after the given delays.
    // Returns in the WRESP cycle.
    task automatic a_wbeat(input logic [AW-1:0] ea, input logic [31:0] ed,
                           input int aw_dly, input int w_dly);
        int m;
        m = (aw_dly > w_dly) ? aw_dly : w_dly;
        chk("a_awprot", ifa.awprot, 3'b000);
        for (int c = 0; c <= m; c++) begin
            chk("a_awvalid", ifa.awvalid, (c <= aw_dly));
            if (c <= aw_dly) chk("a_awaddr", ifa.awaddr, ea);
            chk("a_wvalid", ifa.wvalid, (c <= w_dly));
            if (c <= w_dly) begin
                chk("a_wdata", ifa.wdata, ed);
                chk("a_wstrb", ifa.wstrb, 4'hF);
            end
            ifa.awready = (c == aw_dly);
            ifa.wready  = (c == w_dly);
            tick();
        end
        ifa.awready = 1'b0;
        ifa.wready  = 1'b0;
        chk("a_awvalid_done", ifa.awvalid, 1'b0);
        chk("a_wvalid_done", ifa.wvalid, 1'b0);
        chk("a_bready", ifa.bready, 1'b1);
    endtask

    task automatic a_b(input logic [1:0] br);
        ifa.bvalid = 1'b1;
        ifa.bresp  = br;
        tick();
        ifa.bvalid = 1'b0;
        ifa.bresp  = 2'b00;
        chk("a_bready_after_b", ifa.bready, 1'b0);
    endtask

    task automatic a_rbeat(input logic [AW-1:0] ea, input logic [31:0] d, input logic [1:0] rr);
        chk("a_arvalid", ifa.arvalid, 1'b1);
        chk("a_araddr", ifa.araddr, ea);
        chk("a_arprot", ifa.arprot, 3'b000);
        chk("a_awvalid_in_read", ifa.awvalid, 1'b0);
        ifa.arready = 1'b1;
        tick();
        ifa.arready = 1'b0;
        chk("a_arvalid_done", ifa.arvalid, 1'b0);
        chk("a_rready", ifa.rready, 1'b1);
        ifa.rvalid = 1'b1;
        ifa.rdata  = d;
        ifa.rresp  = rr;
        tick();
        ifa.rvalid = 1'b0;
        ifa.rdata  = 32'h0;
        ifa.rresp  = 2'b00;
        chk("a_rready_after_r", ifa.rready, 1'b0);
    endtask

    task automatic a_rsp(input logic err, input logic [63:0] rd);
        chk("a_rsp_valid", ifa.rsp_valid, 1'b1);
        chk("a_rsp_err", ifa.rsp_err, err);
        chk("a_rsp_rdata", ifa.rsp_rdata, rd);
        ifa.rsp_ready = 1'b1;
        tick();
        ifa.rsp_ready = 1'b0;
        chk("a_rsp_valid_done", ifa.rsp_valid, 1'b0);
        chk("a_cmd_ready_after_rsp", ifa.cmd_ready, 1'b1);
    endtask

    initial begin
        int n;
        {ifa.cmd_valid, ifa.cmd_wen, ifa.rsp_ready, ifa.awready, ifa.wready,
         ifa.bvalid, ifa.arready, ifa.rvalid} = '0;
        ifa.cmd_addr = '0; ifa.cmd_wdata = '0; ifa.bresp = '0; ifa.rdata = '0; ifa.rresp = '0;
        {ifb.cmd_valid, ifb.cmd_wen, ifb.rsp_ready, ifb.awready, ifb.wready,
         ifb.bvalid, ifb.arready, ifb.rvalid} = '0;
        ifb.cmd_addr = '0; ifb.cmd_wdata = '0; ifb.bresp = '0; ifb.rdata = '0; ifb.rresp = '0;

        // Reset state
        aresetn = 1'b0;
        repeat (3) tick();
        chk("rst_awvalid", ifa.awvalid, 1'b0);
        chk("rst_wvalid", ifa.wvalid, 1'b0);
        chk("rst_arvalid", ifa.arvalid, 1'b0);
        chk("rst_bready", ifa.bready, 1'b0);
        chk("rst_rready", ifa.rready, 1'b0);
        chk("rst_rsp_valid", ifa.rsp_valid, 1'b0);
        chk("rst_rsp_err", ifa.rsp_err, 1'b0);
        chk("rst_cmd_ready_a", ifa.cmd_ready, 1'b0);
        chk("rst_cmd_ready_b", ifb.cmd_ready, 1'b0);
        aresetn = 1'b1;
        tick();
        chk("rel_cmd_ready_a", ifa.cmd_ready, 1'b1);
        chk("rel_cmd_ready_b", ifb.cmd_ready, 1'b1);

        // Single-beat write 0xDEADBEEF to 0x10, zero-wait slave: rsp_valid in cycle 3
        ifb.awready = 1'b1;
        ifb.wready  = 1'b1;
        ifb.cmd_valid = 1'b1; ifb.cmd_wen = 1'b1;
        ifb.cmd_addr = 16'h0010; ifb.cmd_wdata = 32'hDEADBEEF;
        tick();                                   // edge 0: accept
        ifb.cmd_valid = 1'b0;
        chk("b_c1_awvalid", ifb.awvalid, 1'b1);
        chk("b_c1_wvalid", ifb.wvalid, 1'b1);
        chk("b_c1_awaddr", ifb.awaddr, 16'h0010);
        chk("b_c1_wdata", ifb.wdata, 32'hDEADBEEF);
        chk("b_c1_wstrb", ifb.wstrb, 4'hF);
        chk("b_c1_awprot", ifb.awprot, 3'b000);
        chk("b_c1_cmd_ready", ifb.cmd_ready, 1'b0);
        tick();                                   // edge 1: AW+W handshake
        ifb.awready = 1'b0;
        ifb.wready  = 1'b0;
        chk("b_c2_awvalid", ifb.awvalid, 1'b0);
        chk("b_c2_wvalid", ifb.wvalid, 1'b0);
        chk("b_c2_bready", ifb.bready, 1'b1);
        chk("b_c2_rsp_valid", ifb.rsp_valid, 1'b0);
        ifb.bvalid = 1'b1; ifb.bresp = 2'b00;
        tick();                                   // edge 2: B handshake
        ifb.bvalid = 1'b0;
        chk("b_c3_rsp_valid", ifb.rsp_valid, 1'b1);
        chk("b_c3_rsp_err", ifb.rsp_err, 1'b0);
        chk("b_c3_rsp_rdata", ifb.rsp_rdata, 32'h0);
        chk("b_c3_bready", ifb.bready, 1'b0);
        ifb.rsp_ready = 1'b1;
        tick();
        ifb.rsp_ready = 1'b0;
        chk("b_c4_rsp_valid", ifb.rsp_valid, 1'b0);
        chk("b_c4_cmd_ready", ifb.cmd_ready, 1'b1);

        // Single-beat read of 0x17: byte-select bits ignored -> araddr 0x14
        ifb.cmd_valid = 1'b1; ifb.cmd_wen = 1'b0; ifb.cmd_addr = 16'h0017;
        tick();
        ifb.cmd_valid = 1'b0;
        chk("b_rd_arvalid", ifb.arvalid, 1'b1);
        chk("b_rd_araddr", ifb.araddr, 16'h0014);
        ifb.arready = 1'b1;
        tick();
        ifb.arready = 1'b0;
        chk("b_rd_rready", ifb.rready, 1'b1);
        ifb.rvalid = 1'b1; ifb.rdata = 32'h5A5A0001; ifb.rresp = 2'b00;
        tick();
        ifb.rvalid = 1'b0;
        chk("b_rd_rsp_valid", ifb.rsp_valid, 1'b1);
        chk("b_rd_rsp_rdata", ifb.rsp_rdata, 32'h5A5A0001);
        chk("b_rd_rsp_err", ifb.rsp_err, 1'b0);
        ifb.rsp_ready = 1'b1;
        tick();
        ifb.rsp_ready = 1'b0;

        // Two-beat read of 0x20
        a_cmd(1'b0, 16'h0020, 64'h0);
        a_rbeat(16'h0020, 32'h11111111, 2'b00);
        a_rbeat(16'h0024, 32'h22222222, 2'b00);
        a_rsp(1'b0, 64'h2222222211111111);

        // awready 3 cycles before wready, then the reverse
        a_cmd(1'b1, 16'h0040, 64'hCAFEF00D_12345678);
        a_wbeat(16'h0040, 32'h12345678, 0, 3);
        a_b(2'b00);
        a_wbeat(16'h0044, 32'hCAFEF00D, 3, 0);
        a_b(2'b00);
        a_rsp(1'b0, 64'h0);

        // awready and wready in the same cycle (immediately, then after 2 waits)
        a_cmd(1'b1, 16'h004F, 64'h0BADF00D_00000001);
        a_wbeat(16'h0048, 32'h00000001, 0, 0);
        a_b(2'b00);
        a_wbeat(16'h004C, 32'h0BADF00D, 2, 2);
        a_b(2'b00);
        a_rsp(1'b0, 64'h0);

        // SLVERR on beat 0: beat 1 still issued, error reported
        a_cmd(1'b1, 16'h0050, 64'hAAAA5555_33334444);
        a_wbeat(16'h0050, 32'h33334444, 0, 0);
        a_b(2'b10);
        a_wbeat(16'h0054, 32'hAAAA5555, 0, 0);
        a_b(2'b00);
        a_rsp(1'b1, 64'h0);

        // Following read with OKAY clears the error; low address bits ignored
        a_cmd(1'b0, 16'h002C, 64'h0);
        a_rbeat(16'h0028, 32'h89ABCDEF, 2'b00);
        a_rbeat(16'h002C, 32'h01234567, 2'b00);
        a_rsp(1'b0, 64'h01234567_89ABCDEF);

        // DECERR on the last read beat: data still returned, error set
        a_cmd(1'b0, 16'h0008, 64'h0);
        a_rbeat(16'h0008, 32'h0000BEEF, 2'b00);
        a_rbeat(16'h000C, 32'h0000FACE, 2'b11);
        a_rsp(1'b1, 64'h0000FACE_0000BEEF);

        // rsp_ready held low for 5 cycles
        a_cmd(1'b0, 16'h0030, 64'h0);
        a_rbeat(16'h0030, 32'h76543210, 2'b00);
        a_rbeat(16'h0034, 32'hFEDCBA98, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", ifa.rsp_valid, 1'b1);
            chk("stall_rsp_rdata", ifa.rsp_rdata, 64'hFEDCBA98_76543210);
            chk("stall_cmd_ready", ifa.cmd_ready, 1'b0);
            tick();
        end
        a_rsp(1'b0, 64'hFEDCBA98_76543210);

        // Reset pulse while waiting in WRESP
        a_cmd(1'b1, 16'h0060, 64'h12121212_34343434);
        a_wbeat(16'h0060, 32'h34343434, 0, 0);
        aresetn = 1'b0;
        tick();
        chk("mid_rst_awvalid", ifa.awvalid, 1'b0);
        chk("mid_rst_wvalid", ifa.wvalid, 1'b0);
        chk("mid_rst_bready", ifa.bready, 1'b0);
        chk("mid_rst_rsp_valid", ifa.rsp_valid, 1'b0);
        chk("mid_rst_cmd_ready", ifa.cmd_ready, 1'b0);
        aresetn = 1'b1;
        tick();
        chk("post_rst_cmd_ready", ifa.cmd_ready, 1'b1);
        chk("post_rst_awvalid", ifa.awvalid, 1'b0);
        chk("post_rst_arvalid", ifa.arvalid, 1'b0);
        chk("post_rst_bready", ifa.bready, 1'b0);
        chk("post_rst_rsp_valid", ifa.rsp_valid, 1'b0);
        a_cmd(1'b0, 16'h0070, 64'h0);
        a_rbeat(16'h0070, 32'h0000A001, 2'b00);
        a_rbeat(16'h0074, 32'h0000B002, 2'b00);
        a_rsp(1'b0, 64'h0000B002_0000A001);

`ifdef AXILITE_INITIATOR_TIMEOUT_EN
        // Slave never asserts arready: arvalid held 16 cycles, then error response
        a_cmd(1'b0, 16'h0080, 64'h0);
        n = 0;
        while (ifa.arvalid === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("tmo_arvalid_cycles", n, 16);
        chk("tmo_arvalid_low", ifa.arvalid, 1'b0);
        chk("tmo_rready_low", ifa.rready, 1'b0);
        a_rsp(1'b1, 64'h0);
`else
        n = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
